// File: rtl/ntt_pair_scheduler.sv
// ntt_pair_scheduler
//   Operand scheduler for an in-place radix-2 NTT/INTT datapath. It walks
//   every stage of an N = 2^log_n point transform and issues one butterfly
//   per accepted handshake. Each butterfly carries the coefficient pair
//   addresses, the twiddle index and the mode select. The matching
//   write-back addresses come out of a free-running delay line that is
//   pipe_depth cycles deep.
//
//   Parameters
//     log_n      : log2 of transform size (2..15)
//     pipe_depth : cycles from an accepted read to its write-back (>= 1)
//
//   Ports
//     clk, rst              : clock and synchronous active-high reset
//     start, mode           : begin a transform; mode 0 = NTT (CT), 1 = INTT (GS)
//     busy, done            : activity flag and one-cycle completion pulse
//     rd_valid, rd_ready    : butterfly request handshake
//     rd_addr_a, rd_addr_b  : coefficient pair addresses
//     tw_idx, bf_select     : twiddle index and latched mode
//     stage                 : current stage number
//     wr_en, wr_addr_a/b    : write-back strobe and addresses
//
//   Configuration macro
//     NTT_SCHED_STAGE_DRAIN_EN : when defined, the pipeline drains between
//     every pair of stages. When undefined, stages run back to back and the
//     pipeline drains only after the final stage.

module ntt_pair_scheduler #(
    parameter int unsigned log_n      = 8,
    parameter int unsigned pipe_depth = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [log_n-1:0] rd_addr_a,
    output logic [log_n-1:0] rd_addr_b,
    output logic [log_n-1:0] tw_idx,
    output logic             bf_select,
    output logic [3:0]       stage,
    output logic             wr_en,
    output logic [log_n-1:0] wr_addr_a,
    output logic [log_n-1:0] wr_addr_b
);

    localparam int unsigned DW        = $clog2(pipe_depth + 1);
    localparam int unsigned K_LAST_I  = (1 << (log_n - 1)) - 1;
    localparam int unsigned S_LAST_I  = log_n - 1;
    localparam int unsigned D_LAST_I  = pipe_depth - 1;
    localparam logic [log_n-1:0] K_LAST = K_LAST_I[log_n-1:0];
    localparam logic [3:0]       S_LAST = S_LAST_I[3:0];
    localparam logic [DW-1:0]    D_LAST = D_LAST_I[DW-1:0];
    localparam logic [log_n-1:0] ONE    = {{(log_n-1){1'b0}}, 1'b1};
    localparam int unsigned      EW     = 2 * log_n + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       s_q, s_d;
    logic [log_n-1:0] k_q, k_d;
    logic             mode_q, mode_d;
    logic [DW-1:0]    cnt_q, cnt_d;

    logic [log_n-1:0] a_q, a_d;
    logic [log_n-1:0] b_q, b_d;
    logic [log_n-1:0] tw_q, tw_d;

    logic [EW-1:0]    dl_q [pipe_depth];

    logic             accept;

    assign rd_valid  = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign accept    = rd_valid && rd_ready;
    assign rd_addr_a = a_q;
    assign rd_addr_b = b_q;
    assign tw_idx    = tw_q;
    assign bf_select = mode_q;
    assign stage     = s_q;

    assign wr_en     = dl_q[pipe_depth-1][EW-1];
    assign wr_addr_a = dl_q[pipe_depth-1][2*log_n-1:log_n];
    assign wr_addr_b = dl_q[pipe_depth-1][log_n-1:0];

    // Next-state logic for the stage/index walk.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    s_d     = '0;
                    k_d     = '0;
                    mode_d  = mode;
                end
            end
            S_ISSUE: begin
                if (rd_ready) begin
                    if (k_q == K_LAST) begin
                        k_d = '0;
`ifdef NTT_SCHED_STAGE_DRAIN_EN
                        state_d = S_DRAIN;
                        cnt_d   = '0;
`else
                        // Back-to-back stages: only the final stage drains.
                        if (s_q == S_LAST) begin
                            state_d = S_DRAIN;
                            cnt_d   = '0;
                        end else begin
                            s_d = s_q + 4'd1;
                        end
`endif
                    end else begin
                        k_d = k_q + ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == D_LAST) begin
`ifdef NTT_SCHED_STAGE_DRAIN_EN
                    if (s_q == S_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        s_d     = s_q + 4'd1;
                    end
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                s_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address generation from the next (s, k) so that outputs are registered.
    // NTT butterflies span d = N >> (s+1); INTT butterflies span d = 1 << s.
    always_comb begin
        int unsigned      lg;
        logic [log_n-1:0] d;
        logic [log_n-1:0] g;
        logic [log_n-1:0] j;
        lg = '0;
        d  = '0;
        g  = '0;
        j  = '0;
        if (mode_d) begin
            lg = {28'd0, s_d};
        end else begin
            lg = (log_n - 1) - {28'd0, s_d};
        end
        d = ONE << lg;
        g = k_d >> lg;
        j = k_d & (d - ONE);
        a_d = (g << (lg + 1)) | j;
        b_d = a_d + d;
        if (mode_d) begin
            tw_d = (ONE << ((log_n - 1) - {28'd0, s_d})) + g;
        end else begin
            tw_d = (ONE << s_d) + g;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tw_q    <= tw_d;
        end
    end

    // Free-running write-back delay line; reset drops any pairs in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < pipe_depth; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= {accept, a_q, b_q};
            for (int unsigned i = 1; i < pipe_depth; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ntt_pair_scheduler.sv
module tb_ntt_pair_scheduler;

    localparam int P = 3;
`ifdef NTT_SCHED_STAGE_DRAIN_EN
    localparam bit DRAIN_EN  = 1'b1;
    localparam int DONE_CYC  = 22;
    localparam int ABORT_CYC = 10;
`else
    localparam bit DRAIN_EN  = 1'b0;
    localparam int DONE_CYC  = 16;
    localparam int ABORT_CYC = 7;
`endif

    logic       clk, rst, start, mode, rd_ready;
    logic       busy, done, rd_valid, bf_select, wr_en;
    logic [2:0] rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b;
    logic [3:0] stage;

    int checks = 0;
    int errors = 0;

    // Hand-computed butterfly order for log_n = 3.
    int ntt_a  [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int ntt_b  [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int ntt_t  [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
    int intt_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int intt_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int intt_t [12] = '{4, 5, 6, 7, 2, 2, 3, 3, 1, 1, 1, 1};

    ntt_pair_scheduler #(.log_n(3), .pipe_depth(P)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
        .bf_select(bf_select), .stage(stage), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " rd_valid"}, 32'(rd_valid), 0);
        chk({tag, " wr_en"}, 32'(wr_en), 0);
        chk({tag, " rd_addr_a"}, 32'(rd_addr_a), 0);
        chk({tag, " rd_addr_b"}, 32'(rd_addr_b), 0);
        chk({tag, " tw_idx"}, 32'(tw_idx), 0);
        chk({tag, " stage"}, 32'(stage), 0);
        chk({tag, " bf_select"}, 32'(bf_select), 0);
    endtask

    // One transform: m = mode, stall = ready pattern 1,0,0,..., poke = start
    // pulse with flipped mode while busy, abort_at = cycle to assert reset (0 = never).
    task automatic run_xfer(input logic m, input bit stall, input bit poke, input int abort_at);
        int  idx = 0;
        int  next_issue = 1;
        int  last_acc = 0;
        bit  finished = 1'b0;
        bit  acc_h [256];
        int  wa_h [256];
        int  wb_h [256];
        bit  exp_valid, acc, exp_wr, exp_done;
        int  ea, eb, et;
        for (int i = 0; i < 256; i++) begin
            acc_h[i] = 1'b0;
            wa_h[i]  = 0;
            wb_h[i]  = 0;
        end
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 200; c++) begin
            if (c == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk_idle_zero("abort");
                rst = 1'b0;
                for (int w = 0; w < 12; w++) begin
                    @(negedge clk);
                    chk("post-reset wr_en", 32'(wr_en), 0);
                    chk("post-reset busy", 32'(busy), 0);
                end
                return;
            end
            rd_ready = stall ? ((c % 3) == 1) : 1'b1;
            if (poke && c == 5) begin
                start = 1'b1;
                mode  = ~m;
            end
            if (poke && c == 6) begin
                start = 1'b0;
                mode  = m;
            end
            exp_valid = (idx < 12) && (c >= next_issue);
            chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
            if (exp_valid) begin
                ea = m ? intt_a[idx] : ntt_a[idx];
                eb = m ? intt_b[idx] : ntt_b[idx];
                et = m ? intt_t[idx] : ntt_t[idx];
                chk("rd_addr_a", 32'(rd_addr_a), ea);
                chk("rd_addr_b", 32'(rd_addr_b), eb);
                chk("tw_idx", 32'(tw_idx), et);
                chk("stage", 32'(stage), idx / 4);
                wa_h[c] = ea;
                wb_h[c] = eb;
            end
            chk("bf_select", 32'(bf_select), 32'(m));
            chk("busy", 32'(busy), 1);
            acc = exp_valid && rd_ready;
            acc_h[c] = acc;
            exp_wr = (c > P) ? acc_h[c-P] : 1'b0;
            chk("wr_en", 32'(wr_en), 32'(exp_wr));
            if (exp_wr) begin
                chk("wr_addr_a", 32'(wr_addr_a), wa_h[c-P]);
                chk("wr_addr_b", 32'(wr_addr_b), wb_h[c-P]);
            end
            exp_done = (idx == 12) && (c == last_acc + P + 1);
            chk("done", 32'(done), 32'(exp_done));
            if (acc) begin
                if (DRAIN_EN && (idx % 4) == 3 && idx != 11)
                    next_issue = c + P + 1;
                else
                    next_issue = c + 1;
                last_acc = c;
                idx++;
            end
            if (exp_done) begin
                finished = 1'b1;
                if (!stall) chk("done cycle", c, DONE_CYC);
                break;
            end
            @(negedge clk);
        end
        if (!finished) begin
            chk("timeout", 0, 1);
        end else begin
            @(negedge clk);
            chk("idle busy", 32'(busy), 0);
            chk("idle done", 32'(done), 0);
            chk("idle wr_en", 32'(wr_en), 0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b0;

        run_xfer(1'b0, 1'b0, 1'b0, 0);          // NTT, no stall
        run_xfer(1'b1, 1'b0, 1'b0, 0);          // INTT, no stall
        run_xfer(1'b0, 1'b1, 1'b0, 0);          // NTT with 1,0,0 ready pattern
        run_xfer(1'b0, 1'b0, 1'b0, ABORT_CYC);  // reset mid stage 1
        run_xfer(1'b0, 1'b0, 1'b0, 0);          // fresh start after reset
        run_xfer(1'b1, 1'b0, 1'b1, 0);          // start/mode poked while busy

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
